// File: rtl/hs_npu_activation_pipe.sv
// Two-stage activation pipeline for NPU accumulator lanes.
// S1 applies ReLU, rounding and the arithmetic shift; S2 saturates or truncates to the output width.
module hs_npu_activation_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_WIDTH = 16,
  parameter int LANES        = 4,
  parameter int SHIFT_WIDTH  = 6
) (
  input  logic                          clk_core,
  input  logic                          rst_core_n,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          relu_en,
  input  logic                          round_en,
  input  logic                          sat_en,
  input  logic [SHIFT_WIDTH-1:0]        shift_amount,
  output logic [LANES*OUTPUT_WIDTH-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0]              sat_flag,
  output logic [15:0]                   sat_count,
  input  logic                          sat_count_clr
);

  localparam logic signed [DATA_WIDTH:0] ONE     = {{DATA_WIDTH{1'b0}}, 1'b1};
  localparam logic signed [DATA_WIDTH:0] SAT_MAX =
    {{(DATA_WIDTH-OUTPUT_WIDTH+2){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0] SAT_MIN =
    {{(DATA_WIDTH-OUTPUT_WIDTH+2){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  logic                           s1_valid_q;
  logic [LANES-1:0][DATA_WIDTH:0] s1_data_q, s1_data_d;
  logic                           s1_sat_en_q;
  logic                           s2_valid_q;
  logic [LANES*OUTPUT_WIDTH-1:0]  s2_data_q, s2_data_d;
  logic [LANES-1:0]               s2_flag_q, s2_flag_d;
  logic [15:0]                    sat_count_q, sat_count_d;

  logic s2_free, in_fire, out_fire;

  assign s2_free  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  // Stage 1: ReLU, optional round-half-up bias, arithmetic shift in DATA_WIDTH+1 bits.
  logic                          big_shift;
  logic signed [DATA_WIDTH-1:0]  lane_v;
  logic signed [DATA_WIDTH:0]    ext_v, bias_v, shv_v;

  always_comb begin
    s1_data_d = '0;
    lane_v    = '0;
    ext_v     = '0;
    bias_v    = '0;
    shv_v     = '0;
    big_shift = (32'(shift_amount) >= 32'(DATA_WIDTH));
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_v = $signed(in_data[k*DATA_WIDTH +: DATA_WIDTH]);
      if (relu_en && lane_v[DATA_WIDTH-1]) begin
        lane_v = '0;
      end
      ext_v  = {lane_v[DATA_WIDTH-1], lane_v};
      bias_v = '0;
      if (round_en && (shift_amount != '0) && !big_shift) begin
        bias_v = ONE << (shift_amount - SHIFT_WIDTH'(1));
      end
      if (big_shift) begin
        shv_v = {(DATA_WIDTH+1){ext_v[DATA_WIDTH]}};
      end else begin
        shv_v = (ext_v + bias_v) >>> shift_amount;
      end
      s1_data_d[k] = shv_v;
    end
  end

  // Stage 2: clamp (flagging the lane) or plain truncation.
  logic signed [DATA_WIDTH:0] v2;

  always_comb begin
    s2_data_d = '0;
    s2_flag_d = '0;
    v2        = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      v2 = s1_data_q[k];
      if (s1_sat_en_q && (v2 > SAT_MAX)) begin
        s2_data_d[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = SAT_MAX[OUTPUT_WIDTH-1:0];
        s2_flag_d[k] = 1'b1;
      end else if (s1_sat_en_q && (v2 < SAT_MIN)) begin
        s2_data_d[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = SAT_MIN[OUTPUT_WIDTH-1:0];
        s2_flag_d[k] = 1'b1;
      end else begin
        s2_data_d[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = v2[OUTPUT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_count_clr) begin
      sat_count_d = '0;
    end else if (out_fire && (|s2_flag_q) && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_sat_en_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_flag_q   <= '0;
      sat_count_q <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_fire;
      end
      if (in_fire) begin
        s1_data_q   <= s1_data_d;
        s1_sat_en_q <= sat_en;
      end
      if (s2_free) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s2_free && s1_valid_q) begin
        s2_data_q <= s2_data_d;
        s2_flag_q <= s2_flag_d;
      end
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign sat_flag  = s2_flag_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_hs_npu_activation_pipe.sv
// Scoreboard bench for hs_npu_activation_pipe: accepted beats are modelled and queued,
// outputs are compared against the queue head whenever out_valid is high.
module tb_hs_npu_activation_pipe;

  localparam int DW = 32;
  localparam int OW = 16;
  localparam int L  = 4;
  localparam int SW = 6;

  logic              clk_core = 1'b0;
  logic              rst_core_n = 1'b0;
  logic [L*DW-1:0]   in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              relu_en = 1'b0, round_en = 1'b0, sat_en = 1'b0;
  logic [SW-1:0]     shift_amount = '0;
  logic [L*OW-1:0]   out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [L-1:0]      sat_flag;
  logic [15:0]       sat_count;
  logic              sat_count_clr = 1'b0;

  hs_npu_activation_pipe #(
    .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .LANES(L), .SHIFT_WIDTH(SW)
  ) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .relu_en(relu_en), .round_en(round_en), .sat_en(sat_en), .shift_amount(shift_amount),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat_flag(sat_flag), .sat_count(sat_count), .sat_count_clr(sat_count_clr)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic [L*OW-1:0] data;
    logic [L-1:0]    flag;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt = '0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [L*DW-1:0] d, input logic r, input logic rd,
                                 input logic s, input logic [SW-1:0] sh);
    exp_t        m;
    longint      x, y;
    logic [63:0] yb;
    m.data = '0;
    m.flag = '0;
    for (int k = 0; k < L; k++) begin
      x = longint'($signed(d[k*DW +: DW]));
      if (r && x < 0) x = 0;
      if (int'(sh) >= DW) begin
        y = (x < 0) ? -64'sd1 : 64'sd0;
      end else begin
        if (rd && sh != 0) x = x + (64'sd1 <<< (int'(sh) - 1));
        y = x >>> int'(sh);
      end
      yb = y;
      if (s && y > 32767) begin
        m.data[k*OW +: OW] = 16'h7FFF; m.flag[k] = 1'b1;
      end else if (s && y < -32768) begin
        m.data[k*OW +: OW] = 16'h8000; m.flag[k] = 1'b1;
      end else begin
        m.data[k*OW +: OW] = yb[15:0];
      end
    end
    return m;
  endfunction

  function automatic logic [L*DW-1:0] pk(input logic [31:0] l3, input logic [31:0] l2,
                                        input logic [31:0] l1, input logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  // Monitor: scoreboard compare, sat_count model, push of accepted beats.
  always @(negedge clk_core) begin
    exp_t e;
    if (!rst_core_n) begin
      exp_q.delete();
      exp_cnt = '0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_sat_count", 64'(sat_count), 64'd0);
    end else begin
      check("sat_count", 64'(sat_count), 64'(exp_cnt));
      if (sat_count_clr) exp_cnt = '0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q[0];
          check("out_data", 64'(out_data), 64'(e.data));
          check("sat_flag", 64'(sat_flag), 64'(e.flag));
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (!sat_count_clr && (|e.flag) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
          end
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_data, relu_en, round_en, sat_en, shift_amount));
    end
  end

  always @(posedge clk_core) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [L*DW-1:0] d, input logic r, input logic rd,
                      input logic s, input logic [SW-1:0] sh);
    bit ok;
    in_data = d; relu_en = r; round_en = rd; sat_en = s; shift_amount = sh;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_core);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk_core); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_core); #2;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [31:0] ln[4];
    repeat (3) @(posedge clk_core);
    #1;
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_sat_flag", 64'(sat_flag), 64'd0);
    rst_core_n = 1'b1;
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    // ReLU + shift, rounding both ways, saturation vs truncation
    send(pk(32'd3, 32'd100, 32'h0001_0000, -32'sd5), 1'b1, 1'b0, 1'b0, 6'd4);
    send(pk(32'd0, 32'd0, -32'sd7, 32'd7), 1'b0, 1'b1, 1'b0, 6'd1);
    send(pk(32'd0, 32'd0, -32'sd7, 32'd7), 1'b0, 1'b0, 1'b0, 6'd1);
    drain();
    check("cnt_before_sat", 64'(sat_count), 64'd0);
    send(pk(32'd5, -32'sd40000, 32'd1, 32'h0010_0000), 1'b0, 1'b0, 1'b1, 6'd0);
    drain();
    check("cnt_after_sat", 64'(sat_count), 64'd1);
    send(pk(32'd5, -32'sd40000, 32'd1, 32'h0010_0000), 1'b0, 1'b0, 1'b0, 6'd0);
    send(pk(32'd100, -32'sd1, 32'd100, -32'sd1), 1'b0, 1'b1, 1'b1, 6'd40);
    send(pk(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000), 1'b0, 1'b1, 1'b0, 6'd31);
    drain();

    // Stall: two accepted, third held off until release, then three back-to-back outputs
    out_ready = 1'b0;
    send(pk(32'd1, 32'd2, 32'd3, 32'd4), 1'b0, 1'b0, 1'b1, 6'd0);
    send(pk(32'd5, 32'd6, 32'd7, 32'd8), 1'b0, 1'b0, 1'b1, 6'd0);
    in_data = pk(32'd9, 32'd10, 32'd11, 32'd12); in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_core);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk_core); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_core);
      check("release_no_gap", 64'(out_valid), 64'd1);
      @(posedge clk_core); #1;
      in_valid = 1'b0;
    end
    drain();

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 4; k++)
        ln[k] = ($urandom_range(0, 1) != 0) ? $urandom : (32'($urandom_range(0, 400)) - 32'd200);
      send(pk(ln[3], ln[2], ln[1], ln[0]), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
    end
    rand_rdy = 1'b0;
    @(posedge clk_core); #2;
    out_ready = 1'b1;
    drain();

    // Reset with two beats in flight
    send(pk(32'd11, 32'd22, 32'd33, 32'd44), 1'b0, 1'b0, 1'b0, 6'd0);
    send(pk(32'd55, 32'd66, 32'd77, 32'd88), 1'b0, 1'b0, 1'b0, 6'd0);
    rst_core_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk_core);
    #1;
    rst_core_n = 1'b1;
    check("rst_release_in_ready", 64'(in_ready), 64'd1);
    send(pk(32'd1000, 32'd2000, 32'd3000, 32'd4000), 1'b0, 1'b0, 1'b1, 6'd2);
    drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_core);
      check("no_stale_beat", 64'(out_valid), 64'd0);
    end

    // sat_count saturation at 0xFFFF, then clear taking priority over an increment
    sat_count_clr = 1'b1;
    @(posedge clk_core); #1;
    sat_count_clr = 1'b0;
    for (int n = 0; n < 65540; n++)
      send(pk(32'd0, 32'd0, 32'd0, 32'h0010_0000), 1'b0, 1'b0, 1'b1, 6'd0);
    drain();
    check("cnt_saturated", 64'(sat_count), 64'hFFFF);
    send(pk(32'd0, 32'd0, 32'd0, 32'h0010_0000), 1'b0, 1'b0, 1'b1, 6'd0);
    drain();
    check("cnt_stays_ffff", 64'(sat_count), 64'hFFFF);
    send(pk(32'd0, 32'd0, 32'd0, 32'h0010_0000), 1'b0, 1'b0, 1'b1, 6'd0);
    @(posedge clk_core); #1;
    check("clr_coincide_valid", 64'(out_valid), 64'd1);
    sat_count_clr = 1'b1;
    @(posedge clk_core); #1;
    sat_count_clr = 1'b0;
    check("cnt_cleared", 64'(sat_count), 64'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
